// File: rtl/rdma_pkt_framer_if.sv
// Stream bundle (TDATA/TKEEP/TLAST/TVALID/TREADY) shared by the command, payload and frame-out
// ports of rdma_pkt_framer. The master drives data and valid, the slave drives ready.
interface rdma_pkt_framer_if #(
    parameter int unsigned DW = 512,
    parameter int unsigned KW = DW / 8
);
    logic [DW-1:0] TDATA;
    logic [KW-1:0] TKEEP;
    logic          TLAST;
    logic          TVALID;
    logic          TREADY;

    modport master (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);
    modport slave  (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/rdma_pkt_framer.sv
// RDMA transmit framer: one 64-byte Eth/IPv4/UDP/RDMA header beat per command, then payload pass-through.
// Optional payload length check is enabled by defining RDMA_FRAMER_LEN_CHECK_EN.
module rdma_pkt_framer #(
    parameter int unsigned DATA_WBITS         = 512,
    parameter int unsigned DATA_WBYTS         = DATA_WBITS / 8,
    parameter logic [15:0] LOCAL_SERVER_PORT  = 16'd11111,
    parameter logic [15:0] REMOTE_SERVER_PORT = 16'd32002
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [47:0]        src_mac,
    input  logic [47:0]        dst_mac,
    input  logic [31:0]        src_ip,
    input  logic [31:0]        dst_ip,
    rdma_pkt_framer_if.slave   cmd_if,
    rdma_pkt_framer_if.slave   pld_if,
    rdma_pkt_framer_if.master  out_if,
    output logic               len_err,
    output logic               len_err_sticky
);

    typedef enum logic [2:0] {S_IDLE, S_SUM, S_FOLD, S_HDR, S_PLD} state_e;

    state_e                  state_q;
    logic [63:0]             addr_q;
    logic [15:0]             len_q;
    logic [47:0]             smac_q, dmac_q;
    logic [31:0]             sip_q, dip_q;
    logic [15:0]             ip_id_q;
    logic [31:0]             sum_q, sum_d;
    logic [DATA_WBITS-1:0]   hdr_q, hdr_d;
    logic                    cmd_rdy_q, hdr_vld_q, pld_pass_q, hdr_last_q;
    logic [16:0]             fold1_d;
    logic [15:0]             fold2_d, csum_d;
    logic [511:0]            hdr_be;
    logic                    unused_cmd;

    assign unused_cmd = ^{cmd_if.TKEEP, cmd_if.TLAST};

    always_comb begin
        sum_d = 32'h4500 + 32'h4000 + 32'h4011
              + {16'h0, len_q + 16'd50} + {16'h0, ip_id_q}
              + {16'h0, sip_q[31:16]} + {16'h0, sip_q[15:0]}
              + {16'h0, dip_q[31:16]} + {16'h0, dip_q[15:0]};
        fold1_d = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
        fold2_d = fold1_d[15:0] + {15'h0, fold1_d[16]};
        csum_d  = ~fold2_d;
        // Built in wire order (byte 0 in the MSBs), then flipped so byte n lands in TDATA[8n+7:8n].
        hdr_be = {dmac_q, smac_q, 16'h0800,
                  16'h4500, len_q + 16'd50, ip_id_q, 16'h4000, 16'h4011, csum_d, sip_q, dip_q,
                  LOCAL_SERVER_PORT, REMOTE_SERVER_PORT, len_q + 16'd30, 16'h0000,
                  16'h0122, addr_q, 96'h0};
        hdr_d = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            hdr_d[8*i +: 8] = hdr_be[511 - 8*i -: 8];
        end
    end

    assign cmd_if.TREADY = cmd_rdy_q & ~reset;
    assign pld_if.TREADY = pld_pass_q & out_if.TREADY & ~reset;
    assign out_if.TVALID = ~reset & (hdr_vld_q | (pld_pass_q & pld_if.TVALID));
    assign out_if.TDATA  = pld_pass_q ? pld_if.TDATA : hdr_q;
    assign out_if.TKEEP  = pld_pass_q ? pld_if.TKEEP : {DATA_WBYTS{1'b1}};
    assign out_if.TLAST  = pld_pass_q ? pld_if.TLAST : hdr_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ip_id_q    <= '0;
            cmd_rdy_q  <= 1'b1;
            hdr_vld_q  <= 1'b0;
            pld_pass_q <= 1'b0;
            hdr_last_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_if.TVALID) begin
                        addr_q    <= cmd_if.TDATA[79:16];
                        len_q     <= cmd_if.TDATA[15:0];
                        smac_q    <= src_mac;
                        dmac_q    <= dst_mac;
                        sip_q     <= src_ip;
                        dip_q     <= dst_ip;
                        cmd_rdy_q <= 1'b0;
                        state_q   <= S_SUM;
                    end
                end
                S_SUM: begin
                    sum_q   <= sum_d;
                    state_q <= S_FOLD;
                end
                S_FOLD: begin
                    hdr_q      <= hdr_d;
                    hdr_last_q <= (len_q == 16'd0);
                    hdr_vld_q  <= 1'b1;
                    state_q    <= S_HDR;
                end
                S_HDR: begin
                    if (out_if.TREADY) begin
                        ip_id_q   <= ip_id_q + 16'd1;
                        hdr_vld_q <= 1'b0;
                        if (len_q == 16'd0) begin
                            cmd_rdy_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            pld_pass_q <= 1'b1;
                            state_q    <= S_PLD;
                        end
                    end
                end
                S_PLD: begin
                    if (pld_if.TVALID && out_if.TREADY && pld_if.TLAST) begin
                        pld_pass_q <= 1'b0;
                        cmd_rdy_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef RDMA_FRAMER_LEN_CHECK_EN
    logic [15:0] cnt_q, pop_d;
    logic        len_err_q, sticky_q;
    logic        pld_hs;

    assign pld_hs = pld_pass_q & pld_if.TVALID & out_if.TREADY;

    always_comb begin
        pop_d = '0;
        for (int unsigned i = 0; i < DATA_WBYTS; i++) begin
            pop_d = pop_d + {15'h0, pld_if.TKEEP[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (pld_hs) begin
                if (pld_if.TLAST) begin
                    cnt_q <= '0;
                    if (cnt_q + pop_d != len_q) begin
                        len_err_q <= 1'b1;
                        sticky_q  <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + pop_d;
                end
            end
        end
    end

    assign len_err        = len_err_q;
    assign len_err_sticky = sticky_q;
`else
    assign len_err        = 1'b0;
    assign len_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_rdma_pkt_framer.sv
// Self-checking bench for rdma_pkt_framer: randomized frames checked against a byte-level header model.
module tb_rdma_pkt_framer;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [15:0] len;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;
    logic        len_err, len_err_sticky;

    rdma_pkt_framer_if #(.DW(80))  cmd_if ();
    rdma_pkt_framer_if #(.DW(512)) pld_if ();
    rdma_pkt_framer_if #(.DW(512)) out_if ();

    rdma_pkt_framer #(
        .DATA_WBITS(512), .DATA_WBYTS(64),
        .LOCAL_SERVER_PORT(16'd11111), .REMOTE_SERVER_PORT(16'd32002)
    ) dut (
        .clk(clk), .reset(reset),
        .src_mac(src_mac), .dst_mac(dst_mac), .src_ip(src_ip), .dst_ip(dst_ip),
        .cmd_if(cmd_if), .pld_if(pld_if), .out_if(out_if),
        .len_err(len_err), .len_err_sticky(len_err_sticky)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0, fails = 0;
    beat_t       got_q[$], exp_q[$], pld_q[$];
    cmd_t        cmd_q[$];
    int          cmd_cyc[$], got_cyc[$];
    int          cyc = 0, stall_err = 0, pld_hs = 0, len_err_cnt = 0;
    logic [15:0] exp_id;
    bit          rand_rdy = 0;

    // Reference header: assembled byte by byte in wire order from the protocol field list.
    function automatic logic [511:0] model_hdr(input logic [47:0] dm, input logic [47:0] sm,
                                               input logic [31:0] si, input logic [31:0] di,
                                               input logic [63:0] a, input logic [15:0] len,
                                               input logic [15:0] id);
        logic [7:0]   b [64];
        logic [15:0]  w [10];
        logic [15:0]  f [14];
        logic [15:0]  iplen, udplen, ck;
        int unsigned  s;
        logic [511:0] r;
        iplen  = len + 16'd50;
        udplen = len + 16'd30;
        w = '{16'h4500, iplen, id, 16'h4000, 16'h4011, 16'h0000, si[31:16], si[15:0], di[31:16], di[15:0]};
        s = 0;
        for (int unsigned i = 0; i < 10; i++) s = s + w[i];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        ck = ~s[15:0];
        for (int unsigned i = 0; i < 64; i++) b[i] = 8'h00;
        for (int unsigned i = 0; i < 6; i++) begin
            b[i]     = dm[47 - 8*i -: 8];
            b[6 + i] = sm[47 - 8*i -: 8];
        end
        f = '{16'h0800, 16'h4500, iplen, id, 16'h4000, 16'h4011, ck, si[31:16], si[15:0],
              di[31:16], di[15:0], 16'd11111, 16'd32002, udplen};
        for (int unsigned k = 0; k < 14; k++) begin
            b[12 + 2*k] = f[k][15:8];
            b[13 + 2*k] = f[k][7:0];
        end
        b[42] = 8'h01;
        b[43] = 8'h22;
        for (int unsigned i = 0; i < 8; i++) b[44 + i] = a[63 - 8*i -: 8];
        for (int unsigned n = 0; n < 64; n++) r[8*n +: 8] = b[n];
        return r;
    endfunction

    function automatic logic [15:0] h16(input logic [511:0] d, input int unsigned off);
        return {d[8*off +: 8], d[8*(off + 1) +: 8]};
    endfunction

    // Monitor: everything sampled on the falling edge, inputs change just after the rising edge.
    initial begin
        logic  prev_stall;
        beat_t prev;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!out_if.TVALID || out_if.TDATA !== prev.data ||
                                   out_if.TKEEP !== prev.keep || out_if.TLAST !== prev.last))
                    stall_err++;
                if (cmd_if.TVALID && cmd_if.TREADY) cmd_cyc.push_back(cyc);
                if (pld_if.TVALID && pld_if.TREADY) pld_hs++;
                if (out_if.TVALID && out_if.TREADY) begin
                    got_q.push_back('{out_if.TDATA, out_if.TKEEP, out_if.TLAST});
                    got_cyc.push_back(cyc);
                end
                if (len_err) len_err_cnt++;
                prev_stall = out_if.TVALID && !out_if.TREADY;
                prev = '{out_if.TDATA, out_if.TKEEP, out_if.TLAST};
            end
        end
    end

    initial begin
        out_if.TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.TREADY = rand_rdy ? 1'($urandom % 2) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        got_q.delete(); exp_q.delete(); pld_q.delete(); cmd_q.delete();
        cmd_cyc.delete(); got_cyc.delete();
        stall_err = 0; pld_hs = 0; len_err_cnt = 0; exp_id = 16'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic queue_frame(input logic [63:0] addr, input logic [15:0] len,
                               input int unsigned nb, input int unsigned lastk);
        beat_t       bt;
        logic [63:0] kl;
        cmd_q.push_back('{addr, len});
        exp_q.push_back('{model_hdr(dst_mac, src_mac, src_ip, dst_ip, addr, len, exp_id), '1, nb == 0});
        exp_id = exp_id + 16'd1;
        kl = (lastk >= 64) ? '1 : ((64'd1 << lastk) - 64'd1);
        for (int unsigned j = 0; j < nb; j++) begin
            for (int unsigned w = 0; w < 16; w++) bt.data[32*w +: 32] = $urandom;
            bt.keep = (j == nb - 1) ? kl : '1;
            bt.last = (j == nb - 1);
            pld_q.push_back(bt);
            exp_q.push_back(bt);
        end
    endtask

    task automatic drive_cmd(input cmd_t c);
        int n = 0;
        cmd_if.TDATA  = {c.addr, c.len};
        cmd_if.TVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!cmd_if.TREADY && n < 2000);
        @(posedge clk); #1;
        cmd_if.TVALID = 1'b0;
    endtask

    task automatic drive_pld(input beat_t b);
        int n = 0;
        pld_if.TDATA  = b.data;
        pld_if.TKEEP  = b.keep;
        pld_if.TLAST  = b.last;
        pld_if.TVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!pld_if.TREADY && n < 2000);
        @(posedge clk); #1;
        pld_if.TVALID = 1'b0;
    endtask

    task automatic drive_frames();
        int n = 0;
        @(posedge clk); #1;
        fork
            begin while (cmd_q.size() > 0) drive_cmd(cmd_q.pop_front()); end
            begin while (pld_q.size() > 0) drive_pld(pld_q.pop_front()); end
        join
        while (got_q.size() < exp_q.size() && n < 1000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
    endtask

    task automatic set_scn2_addrs();
        src_ip  = {8'd10, 8'd1, 8'd1, 8'd1};
        dst_ip  = {8'd10, 8'd1, 8'd1, 8'd2};
        src_mac = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
        dst_mac = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_if.TVALID = 1'b0; cmd_if.TDATA = '0; cmd_if.TKEEP = '0; cmd_if.TLAST = 1'b0;
        pld_if.TVALID = 1'b0; pld_if.TDATA = '0; pld_if.TKEEP = '0; pld_if.TLAST = 1'b0;
        src_mac = '0; dst_mac = '0; src_ip = '0; dst_ip = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (cmd_if.TREADY !== 1'b0) begin fails++; $display("FAIL rst_cmd_tready: got %b exp 0", cmd_if.TREADY); end
        tests++; if (pld_if.TREADY !== 1'b0) begin fails++; $display("FAIL rst_pld_tready: got %b exp 0", pld_if.TREADY); end
        tests++; if (out_if.TVALID !== 1'b0) begin fails++; $display("FAIL rst_out_tvalid: got %b exp 0", out_if.TVALID); end
        tests++; if ({len_err, len_err_sticky} !== 2'b00) begin fails++; $display("FAIL rst_len_err: got %b exp 00", {len_err, len_err_sticky}); end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_logs();
        @(negedge clk);
        tests++; if (cmd_if.TREADY !== 1'b1) begin fails++; $display("FAIL idle_cmd_tready: got %b exp 1", cmd_if.TREADY); end
        tests++; if (out_if.TVALID !== 1'b0) begin fails++; $display("FAIL idle_out_tvalid: got %b exp 0", out_if.TVALID); end
    endtask

    task automatic test_zero_len();
        beat_t h;
        rand_rdy = 0;
        src_mac = 48'h0200_0000_0001; dst_mac = 48'h0200_0000_0002;
        src_ip = $urandom; dst_ip = $urandom;
        queue_frame(64'h1122334455667788, 16'd0, 0, 64);
        drive_frames();
        h = (got_q.size() > 0) ? got_q[0] : '0;
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL zl_beats: got %0d exp 1", got_q.size()); end
        tests++; if (h !== exp_q[0]) begin fails++; $display("FAIL zl_hdr: got %h exp %h", h, exp_q[0]); end
        tests++; if (h.last !== 1'b1) begin fails++; $display("FAIL zl_tlast: got %b exp 1", h.last); end
        tests++; if (h16(h.data, 16) !== 16'h0032) begin fails++; $display("FAIL zl_ip4_len: got %h exp 0032", h16(h.data, 16)); end
        tests++; if (h16(h.data, 38) !== 16'h001E) begin fails++; $display("FAIL zl_udp_len: got %h exp 001e", h16(h.data, 38)); end
        tests++; if (h16(h.data, 42) !== 16'h0122) begin fails++; $display("FAIL zl_magic: got %h exp 0122", h16(h.data, 42)); end
        tests++; if (pld_hs != 0) begin fails++; $display("FAIL zl_pld_hs: got %0d exp 0", pld_hs); end
        tests++;
        if (cmd_cyc.size() < 1 || got_cyc.size() < 1 || got_cyc[0] - cmd_cyc[0] != 3) begin
            fails++;
            $display("FAIL zl_latency: got %0d exp 3",
                     (cmd_cyc.size() > 0 && got_cyc.size() > 0) ? got_cyc[0] - cmd_cyc[0] : -1);
        end
    endtask

    task automatic test_basic_frame();
        beat_t h;
        do_reset();
        rand_rdy = 0;
        set_scn2_addrs();
        queue_frame({$urandom, $urandom}, 16'd128, 2, 64);
        drive_frames();
        h = (got_q.size() > 0) ? got_q[0] : '0;
        tests++; if (got_q.size() != 3) begin fails++; $display("FAIL s2_beats: got %0d exp 3", got_q.size()); end
        for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL s2_beat%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (h16(h.data, 16) !== 16'h00B2) begin fails++; $display("FAIL s2_ip4_len: got %h exp 00b2", h16(h.data, 16)); end
        tests++; if (h16(h.data, 18) !== 16'h0000) begin fails++; $display("FAIL s2_ip_id: got %h exp 0000", h16(h.data, 18)); end
        tests++; if (h16(h.data, 24) !== 16'h2437) begin fails++; $display("FAIL s2_csum: got %h exp 2437", h16(h.data, 24)); end
        tests++; if (pld_hs != 2) begin fails++; $display("FAIL s2_pld_hs: got %0d exp 2", pld_hs); end
    endtask

    task automatic test_back_to_back();
        beat_t h;
        do_reset();
        rand_rdy = 0;
        set_scn2_addrs();
        queue_frame({$urandom, $urandom}, 16'd128, 2, 64);
        queue_frame({$urandom, $urandom}, 16'd128, 2, 64);
        drive_frames();
        h = (got_q.size() > 3) ? got_q[3] : '0;
        tests++; if (got_q.size() != 6) begin fails++; $display("FAIL b2b_beats: got %0d exp 6", got_q.size()); end
        for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_beat%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (h16(h.data, 18) !== 16'h0001) begin fails++; $display("FAIL b2b_ip_id: got %h exp 0001", h16(h.data, 18)); end
        tests++; if (h16(h.data, 24) !== 16'h2436) begin fails++; $display("FAIL b2b_csum: got %h exp 2436", h16(h.data, 24)); end
        tests++;
        if (cmd_cyc.size() < 2 || got_cyc.size() < 4 || cmd_cyc[1] - got_cyc[2] != 1 || got_cyc[3] - cmd_cyc[1] != 3) begin
            fails++;
            $display("FAIL b2b_gap: got cmd2-last1=%0d hdr2-cmd2=%0d exp 1 and 3",
                     (cmd_cyc.size() > 1 && got_cyc.size() > 2) ? cmd_cyc[1] - got_cyc[2] : -1,
                     (cmd_cyc.size() > 1 && got_cyc.size() > 3) ? got_cyc[3] - cmd_cyc[1] : -1);
        end
    endtask

    task automatic test_backpressure();
        int unsigned nb, lk, total_pld;
        do_reset();
        rand_rdy = 1;
        src_mac = {$urandom, $urandom}; dst_mac = {$urandom, $urandom};
        src_ip = $urandom; dst_ip = $urandom;
        total_pld = 0;
        for (int unsigned f = 0; f < 8; f++) begin
            nb = (f == 3) ? 0 : $urandom_range(1, 4);
            lk = $urandom_range(1, 64);
            queue_frame({$urandom, $urandom}, (nb == 0) ? 16'd0 : 16'((nb - 1) * 64 + lk), nb, lk);
            total_pld += nb;
        end
        drive_frames();
        rand_rdy = 0;
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_beats: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_beat%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (stall_err != 0) begin fails++; $display("FAIL bp_stall_stable: got %0d changes exp 0", stall_err); end
        tests++; if (pld_hs != int'(total_pld)) begin fails++; $display("FAIL bp_pld_hs: got %0d exp %0d", pld_hs, total_pld); end
        tests++; if (len_err_cnt != 0 || len_err_sticky !== 1'b0) begin fails++; $display("FAIL bp_no_len_err: got %0d/%b exp 0/0", len_err_cnt, len_err_sticky); end
    endtask

    task automatic test_reset_mid_frame();
        beat_t h;
        int    n;
        do_reset();
        rand_rdy = 0;
        set_scn2_addrs();
        @(posedge clk); #1;
        cmd_if.TDATA = {64'hA5A5_5A5A_0F0F_F0F0, 16'd128};
        cmd_if.TVALID = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (!cmd_if.TREADY && n < 100);
        @(posedge clk); #1;
        cmd_if.TVALID = 1'b0;
        pld_if.TDATA = {16{$urandom}}; pld_if.TKEEP = '1; pld_if.TLAST = 1'b0; pld_if.TVALID = 1'b1;
        n = 0; do begin @(negedge clk); n++; end while (!pld_if.TREADY && n < 100);
        @(posedge clk); #1;
        pld_if.TDATA = {16{$urandom}}; pld_if.TLAST = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        tests++; if ({out_if.TVALID, pld_if.TREADY, cmd_if.TREADY} !== 3'b000) begin
            fails++; $display("FAIL mid_rst_outputs: got %b exp 000", {out_if.TVALID, pld_if.TREADY, cmd_if.TREADY}); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pld_if.TVALID = 1'b0; pld_if.TLAST = 1'b0;
        @(negedge clk);
        tests++; if (got_q.size() != 2 || got_q[0].last !== 1'b0 || got_q[1].last !== 1'b0) begin
            fails++; $display("FAIL mid_rst_truncated: got %0d beats exp 2 without tlast", got_q.size()); end
        tests++; if (cmd_if.TREADY !== 1'b1) begin fails++; $display("FAIL mid_rst_idle: got %b exp 1", cmd_if.TREADY); end
        clear_logs();
        queue_frame({$urandom, $urandom}, 16'd128, 2, 64);
        drive_frames();
        h = (got_q.size() > 0) ? got_q[0] : '0;
        tests++; if (got_q.size() != 3) begin fails++; $display("FAIL mid_rst_beats: got %0d exp 3", got_q.size()); end
        for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL mid_rst_beat%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (h16(h.data, 18) !== 16'h0000 || h16(h.data, 24) !== 16'h2437) begin
            fails++; $display("FAIL mid_rst_id_csum: got %h/%h exp 0000/2437", h16(h.data, 18), h16(h.data, 24)); end
    endtask

    task automatic test_len_check();
        do_reset();
        rand_rdy = 0;
        set_scn2_addrs();
        queue_frame({$urandom, $urandom}, 16'd128, 1, 64);
        drive_frames();
        tests++; if (got_q.size() != 2) begin fails++; $display("FAIL lc_beats: got %0d exp 2", got_q.size()); end
        for (int unsigned i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL lc_beat%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
`ifdef RDMA_FRAMER_LEN_CHECK_EN
        tests++; if (len_err_cnt != 1) begin fails++; $display("FAIL lc_pulse: got %0d cycles exp 1", len_err_cnt); end
        tests++; if (len_err_sticky !== 1'b1) begin fails++; $display("FAIL lc_sticky: got %b exp 1", len_err_sticky); end
`else
        tests++; if (len_err_cnt != 0) begin fails++; $display("FAIL lc_pulse: got %0d cycles exp 0", len_err_cnt); end
        tests++; if (len_err_sticky !== 1'b0) begin fails++; $display("FAIL lc_sticky: got %b exp 0", len_err_sticky); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_basic_frame();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_len_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
